// File: rtl/dec_pkg.sv
// Shared types and constants for the registered one-hot decoder.
//   state_t      : controller states (IDLE, HOLD, SCAN)
//   MODE_DECODE  : mode input value selecting handshake-driven decode
//   MODE_SCAN    : mode input value selecting the auto-walking scan
//   dwell_width  : width of a down-counter that must hold DWELL-1
package dec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic MODE_DECODE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // A dwell of 1 still needs a 1-bit counter (it simply stays at 0).
    function automatic int dwell_width(input int dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/decoder_n2m_seq_onehot_dec.sv
// Combinational SEL_W-to-2^SEL_W one-hot decoder with enable.
//   en   : in  1          low forces an all-zero output
//   sel  : in  SEL_W      index of the bit to raise
//   out  : out 2**SEL_W   one-hot (or zero when disabled)
module onehot_dec #(
    parameter int SEL_W = 2
) (
    input  logic                   en,
    input  logic [SEL_W-1:0]       sel,
    output logic [(2**SEL_W)-1:0]  out
);

    localparam int OUT_W = 2**SEL_W;

    assign out = en ? (OUT_W'(1) << sel) : '0;

endmodule

// File: rtl/decoder_n2m_seq.sv
// Registered one-hot decoder with two modes:
//   DECODE - a select accepted through in_valid/in_ready is latched onto f.
//   SCAN   - the active bit of f walks 0..OUT_W-1, each held for DWELL cycles.
// Ports:
//   clk       : in  1       rising-edge clock
//   rst       : in  1       asynchronous active-high reset
//   en        : in  1       global enable, low clears everything at the next edge
//   mode      : in  1       MODE_DECODE / MODE_SCAN
//   in_valid  : in  1       in_sel valid (decode mode only)
//   in_sel    : in  SEL_W   select index
//   in_ready  : out 1       combinational, en && decode mode
//   f         : out OUT_W   registered one-hot output, zero when inactive
//   f_valid   : out 1       f holds a live one-hot value
//   scan_wrap : out 1       one-cycle pulse when the scan returns to bit 0
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | outputs inactive, waiting for an accept or scan request
// HOLD  | f holds the last accepted select, new accepts replace it
// SCAN  | f walks the outputs with a DWELL-cycle dwell per bit
module decoder_n2m_seq
    import dec_pkg::*;
#(
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   mode,
    input  logic                   in_valid,
    input  logic [SEL_W-1:0]       in_sel,
    output logic                   in_ready,
    output logic [(2**SEL_W)-1:0]  f,
    output logic                   f_valid,
    output logic                   scan_wrap
);

    localparam int OUT_W = 2**SEL_W;
    localparam int CNT_W = dwell_width(DWELL);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);

    state_t            state;
    logic [SEL_W-1:0]  idx;
    logic [SEL_W-1:0]  idx_next;
    logic [CNT_W-1:0]  dwell_cnt;
    logic [SEL_W-1:0]  dec_sel;
    logic [OUT_W-1:0]  dec_out;

    assign in_ready = en && (mode == MODE_DECODE);
    assign idx_next = idx + SEL_W'(1);

    // One decoder serves both modes: the accepted select in decode mode,
    // bit 0 when entering scan, and the next scan position while scanning.
    always_comb begin
        dec_sel = in_sel;
        if (mode == MODE_SCAN) begin
            dec_sel = (state == SCAN) ? idx_next : '0;
        end
    end

    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_onehot_dec (
        .en  (en),
        .sel (dec_sel),
        .out (dec_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            dwell_cnt <= '0;
            f         <= '0;
            f_valid   <= 1'b0;
            scan_wrap <= 1'b0;
        end else if (!en) begin
            state     <= IDLE;
            idx       <= '0;
            dwell_cnt <= '0;
            f         <= '0;
            f_valid   <= 1'b0;
            scan_wrap <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    scan_wrap <= 1'b0;
                    if (mode == MODE_SCAN) begin
                        state     <= SCAN;
                        idx       <= '0;
                        dwell_cnt <= DWELL_LOAD;
                        f         <= dec_out;
                        f_valid   <= 1'b1;
                    end else if (in_valid) begin
                        state   <= HOLD;
                        f       <= dec_out;
                        f_valid <= 1'b1;
                    end
                end
                SCAN: begin
                    if (mode == MODE_DECODE) begin
                        // Leaving scan drops the outputs; a fresh accept is
                        // needed before f goes live again.
                        state     <= IDLE;
                        idx       <= '0;
                        dwell_cnt <= '0;
                        f         <= '0;
                        f_valid   <= 1'b0;
                        scan_wrap <= 1'b0;
                    end else if (dwell_cnt == '0) begin
                        idx       <= idx_next;
                        dwell_cnt <= DWELL_LOAD;
                        f         <= dec_out;
                        // Stepping off the last index lands back on bit 0.
                        scan_wrap <= &idx;
                    end else begin
                        dwell_cnt <= dwell_cnt - CNT_W'(1);
                        scan_wrap <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    idx       <= '0;
                    dwell_cnt <= '0;
                    f         <= '0;
                    f_valid   <= 1'b0;
                    scan_wrap <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_n2m_seq.sv
// Self-checking bench for decoder_n2m_seq.
// Instance a: SEL_W=2, DWELL=3. Instance b: SEL_W=3, DWELL=1.
module tb_decoder_n2m_seq;

    logic clk;
    logic rst;

    logic       en_a, mode_a, valid_a;
    logic [1:0] sel_a;
    logic       ready_a;
    logic [3:0] f_a;
    logic       fv_a, wrap_a;

    logic       en_b, mode_b, valid_b;
    logic [2:0] sel_b;
    logic       ready_b;
    logic [7:0] f_b;
    logic       fv_b, wrap_b;

    int checks;
    int errors;

    decoder_n2m_seq #(.SEL_W(2), .DWELL(3)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .en        (en_a),
        .mode      (mode_a),
        .in_valid  (valid_a),
        .in_sel    (sel_a),
        .in_ready  (ready_a),
        .f         (f_a),
        .f_valid   (fv_a),
        .scan_wrap (wrap_a)
    );

    decoder_n2m_seq #(.SEL_W(3), .DWELL(1)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .en        (en_b),
        .mode      (mode_b),
        .in_valid  (valid_b),
        .in_sel    (sel_b),
        .in_ready  (ready_b),
        .f         (f_b),
        .f_valid   (fv_b),
        .scan_wrap (wrap_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       mode;
        logic       valid;
        logic [1:0] sel;
        logic [3:0] f;
        logic       fv;
        logic       wrap;
        logic       ready;
    } vec_t;

    vec_t vecs[9];

    // Reference model state for instance a (random phase).
    int         m_st;   // 0 idle, 1 hold, 2 scan
    int         m_t;    // cycles since scan entry
    logic [3:0] m_f;
    logic       m_wrap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string name, input logic [3:0] ef, input logic ewrap, input logic eready);
        check({name, ".f"}, 32'(f_a), 32'(ef));
        check({name, ".f_valid"}, 32'(fv_a), 32'(ef != 4'd0));
        check({name, ".scan_wrap"}, 32'(wrap_a), 32'(ewrap));
        check({name, ".in_ready"}, 32'(ready_a), 32'(eready));
        check({name, ".onehot"}, 32'($onehot0(f_a)), 32'd1);
    endtask

    task automatic do_reset();
        en_a = 0; mode_a = 0; valid_a = 0; sel_a = 0;
        en_b = 0; mode_b = 0; valid_b = 0; sel_b = 0;
        rst = 1;
        tick();
        rst = 0;
        tick();
    endtask

    // Enter scan on instance a and follow it for n edges; k is edges since entry.
    task automatic scan_walk(input int n, input bit noisy);
        en_a = 1; mode_a = 1; valid_a = 0;
        for (int k = 0; k < n; k++) begin
            if (noisy) begin
                valid_a = 1'($urandom);
                sel_a   = 2'($urandom);
            end
            tick();
            check_a("scan", 4'(1 << ((k / 3) % 4)), k == 12, 1'b0);
        end
        valid_a = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        en_a = 0; mode_a = 0; valid_a = 0; sel_a = 0;
        en_b = 0; mode_b = 0; valid_b = 0; sel_b = 0;
        rst = 1;
        #3;
        check_a("reset", 4'd0, 1'b0, 1'b0);
        check("reset_b.f", 32'(f_b), 32'd0);
        tick();
        rst = 0;
        tick();
        check_a("idle", 4'd0, 1'b0, 1'b0);

        // Decode sweep, hold, en=0 blocking an accept, re-accept.
        vecs[0] = '{1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 2'd0, 4'b1000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 2'd2, 4'b1000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            en_a = vecs[i].en; mode_a = vecs[i].mode;
            valid_a = vecs[i].valid; sel_a = vecs[i].sel;
            tick();
            check({"vec", $sformatf("%0d", i), ".f"}, 32'(f_a), 32'(vecs[i].f));
            check({"vec", $sformatf("%0d", i), ".f_valid"}, 32'(fv_a), 32'(vecs[i].fv));
            check({"vec", $sformatf("%0d", i), ".scan_wrap"}, 32'(wrap_a), 32'(vecs[i].wrap));
            check({"vec", $sformatf("%0d", i), ".in_ready"}, 32'(ready_a), 32'(vecs[i].ready));
        end

        // Scan dwell and wrap from IDLE, with in_valid noise that must be ignored.
        do_reset();
        scan_walk(16, 1'b1);

        // Mode switch while f=0100, then a fresh accept.
        do_reset();
        scan_walk(7, 1'b0);
        check_a("pre_switch", 4'b0100, 1'b0, 1'b0);
        mode_a = 0;
        tick();
        check_a("switch", 4'b0000, 1'b0, 1'b1);
        valid_a = 1; sel_a = 2'd3;
        tick();
        check_a("switch_accept", 4'b1000, 1'b0, 1'b1);
        valid_a = 0;

        // Asynchronous reset mid-scan.
        do_reset();
        scan_walk(7, 1'b0);
        #3;
        rst = 1;
        #1;
        check("async_rst.f", 32'(f_a), 32'd0);
        check("async_rst.f_valid", 32'(fv_a), 32'd0);
        check("async_rst.scan_wrap", 32'(wrap_a), 32'd0);
        en_a = 0; mode_a = 0;
        tick();
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_a("post_rst", 4'd0, 1'b0, 1'b0);
        end

        // Instance b: DWELL=1, SEL_W=3.
        do_reset();
        en_b = 1; mode_b = 1; valid_b = 1; sel_b = 3'd5;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("b_scan.f", 32'(f_b), 32'(1 << (k % 8)));
            check("b_scan.f_valid", 32'(fv_b), 32'd1);
            check("b_scan.scan_wrap", 32'(wrap_b), 32'(k > 0 && (k % 8) == 0));
            check("b_scan.in_ready", 32'(ready_b), 32'd0);
        end
        en_b = 0;
        tick();
        check("b_off.f", 32'(f_b), 32'd0);
        check("b_off.scan_wrap", 32'(wrap_b), 32'd0);

        // Randomized run against the reference model.
        do_reset();
        m_st = 0; m_t = 0; m_f = 4'd0; m_wrap = 1'b0;
        for (int c = 0; c < 400; c++) begin
            en_a    = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 11) == 0) mode_a = ~mode_a;
            valid_a = 1'($urandom);
            sel_a   = 2'($urandom);
            if (!en_a) begin
                m_st = 0; m_f = 4'd0; m_wrap = 1'b0;
            end else if (m_st == 2) begin
                if (!mode_a) begin
                    m_st = 0; m_f = 4'd0; m_wrap = 1'b0;
                end else begin
                    m_t++;
                    m_f = 4'(1 << ((m_t / 3) % 4));
                    m_wrap = ((m_t % 12) == 0);
                end
            end else if (mode_a) begin
                m_st = 2; m_t = 0; m_f = 4'b0001; m_wrap = 1'b0;
            end else begin
                m_wrap = 1'b0;
                if (valid_a) begin
                    m_st = 1;
                    m_f = 4'(1 << sel_a);
                end
            end
            tick();
            check_a("rand", m_f, m_wrap, en_a && !mode_a);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
